// File: rtl/keccak_rc_seq.sv
// ============================================================================
// Module   : keccak_rc_seq
// Purpose  : Sequencer that emits one Keccak iota round constant per round.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keccak_rc_seq #(
  parameter int L  = 6,
  parameter int NR = 12 + 2 * L
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        first_round,
  input  logic              step,
  output logic [2**L-1:0]   rc,
  output logic              rc_valid,
  output logic [4:0]        round_idx,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int W = 2 ** L;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SEEK = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;

  localparam logic [4:0] c_NR_M1 = 5'(NR - 1);

  // One step of the FIPS 202 rc(t) LFSR, bit 0 being the output bit.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] n;
    n = {s[6:0], 1'b0};
    if (s[7]) n = n ^ 8'h71;
    return n;
  endfunction

  function automatic logic [7:0] lfsr_adv7(input logic [7:0] s);
    logic [7:0] n;
    n = s;
    for (int k = 0; k < 7; k++) n = lfsr_step(n);
    return n;
  endfunction

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [4:0] r_round;
  logic [4:0] r_first;
  logic       r_done;
  logic       r_err;
  logic [7:0] r_lane     [0:L];
  logic [7:0] w_lane_adv [0:L];

  logic w_fr_ok;
  logic w_at_last;
  logic w_seek_hit;

  assign w_fr_ok    = (first_round <= c_NR_M1);
  assign w_at_last  = (r_round == c_NR_M1);
  assign w_seek_hit = ((r_round + 5'd1) == r_first);

  generate
    for (genvar j = 0; j <= L; j++) begin : g_lane
      assign w_lane_adv[j] = lfsr_adv7(r_lane[j]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (start && w_fr_ok) w_state_nxt = (first_round == 5'd0) ? c_RUN : c_SEEK;
      c_SEEK: if (w_seek_hit) w_state_nxt = c_RUN;
      c_RUN:  if (step && w_at_last) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Lanes are reseeded on every accepted start, so lane j always holds rc(j+7*round).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_round <= 5'd0;
      r_first <= 5'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int j = 0; j <= L; j++) r_lane[j] <= 8'(1 << j);
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            if (w_fr_ok) begin
              r_round <= 5'd0;
              r_first <= first_round;
              for (int j = 0; j <= L; j++) r_lane[j] <= 8'(1 << j);
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        c_SEEK: begin
          r_round <= r_round + 5'd1;
          for (int j = 0; j <= L; j++) r_lane[j] <= w_lane_adv[j];
        end
        c_RUN: begin
          if (step) begin
            if (w_at_last) begin
              r_round <= 5'd0;
              r_done  <= 1'b1;
            end else begin
              r_round <= r_round + 5'd1;
              for (int j = 0; j <= L; j++) r_lane[j] <= w_lane_adv[j];
            end
          end
        end
        default: r_round <= 5'd0;
      endcase
    end
  end

  always_comb begin
    rc        = '0;
    rc_valid  = (r_state == c_RUN);
    busy      = (r_state == c_SEEK) || (r_state == c_RUN);
    last      = rc_valid && w_at_last;
    round_idx = r_round;
    done      = r_done;
    err       = r_err;
    if (r_state == c_RUN) begin
      for (int j = 0; j <= L; j++) rc[(1 << j) - 1] = r_lane[j][0];
    end
  end

  logic [W-1:0] w_unused_w;
  assign w_unused_w = '0;

endmodule

`default_nettype wire

// File: doc/keccak_rc_seq.md
KECCAK_RC_SEQ -- requirements
Module: keccak_rc_seq

Interface
REQ-001 Parameter: L, default 6, log2 of lane width; legal range 0..6.
REQ-002 Parameter: W, default 2**L, lane width in bits (derived, not overridable).
REQ-003 Parameter: NR, default 12+2*L, total round count of Keccak-f[25*W].
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: start  input  1  request new round-constant sequence; sampled only in IDLE.
REQ-007 Port: first_round  input  5  starting round index (Keccak-p reduced-round mode); sampled with start.
REQ-008 Port: step  input  1  consumer accepted current rc; advance to next round.
REQ-009 Port: rc  output  W  iota round constant for round_idx; zero when rc_valid=0.
REQ-010 Port: rc_valid  output  1  rc and round_idx valid.
REQ-011 Port: round_idx  output  5  current round index.
REQ-012 Port: last  output  1  rc_valid and round_idx==NR-1.
REQ-013 Port: busy  output  1  state is SEEK or RUN.
REQ-014 Port: done  output  1  one-cycle pulse after last round consumed.
REQ-015 Port: err  output  1  one-cycle pulse on rejected start.

Function
REQ-016 LFSR rc(t) SHALL follow FIPS 202: 8-bit state, polynomial x^8+x^6+x^5+x^4+1, rc(0)=1, state=1 at t=0.
REQ-017 Round constant bit (2^j)-1, j=0..L, SHALL equal rc(j+7*round_idx); all other rc bits 0.
REQ-018 Implementation SHALL hold L+1 LFSR lanes (lane j seeded at t=j), each advancing exactly 7 LFSR steps per round advance, in one cycle.
REQ-019 States: IDLE, SEEK, RUN; encoding free.
REQ-020 IDLE: start=1 and first_round<NR -> round_idx<=0, all lanes reseeded; next state RUN if first_round==0, else SEEK.
REQ-021 IDLE: start=1 and first_round>=NR -> err=1 next cycle, stay IDLE, no register other than err changes.
REQ-022 SEEK: each cycle advance all lanes one round, round_idx+1; when new round_idx==captured first_round -> RUN; step ignored; rc_valid=0.
REQ-023 Latency: start at cycle 0 with first_round=k -> rc_valid=1 first at cycle k+1.
REQ-024 RUN: rc_valid=1; rc held stable while step=0.
REQ-025 RUN, step=1, round_idx<NR-1 -> next cycle round_idx+1, rc updated; back-to-back steps give one new rc per cycle.
REQ-026 RUN, step=1, round_idx==NR-1 -> next cycle IDLE, done=1, rc_valid=0, round_idx=0.
REQ-027 start while busy SHALL be ignored (no err, no restart).
REQ-028 start in the done cycle SHALL be accepted as in REQ-020.
REQ-029 step outside RUN SHALL have no effect.
REQ-030 Width rule: for L<6, rc is the low W bits of the 64-bit constant of the same index.

Reset
REQ-031 rst=1 at any clock edge, any state -> IDLE, rc=0, rc_valid=0, round_idx=0, last=0, busy=0, done=0, err=0, lanes reseeded; rst has priority over start/step.
REQ-032 rst mid-SEEK or mid-RUN SHALL discard the sequence; no done pulse.

Verification
REQ-033 L=6, start, first_round=0, step every cycle -> rc sequence 0x0000000000000001, 0x0000000000008082, 0x800000000000808A, 0x8000000080008000, ..., round 23 0x8000000080008008 with last=1; done one cycle later.
REQ-034 L=6, first_round=12 -> 12 SEEK cycles, rc_valid at cycle 13 with rc=0x000000008000808B, round_idx=12; 12 rcs total then done.
REQ-035 L=3 (NR=18), first_round=0 -> rc=0x01, 0x82, 0x8A, 0x00 for rounds 0..3; last asserted at round_idx=17.
REQ-036 L=6, first_round=24 -> err=1 for one cycle, busy stays 0; first_round=5 afterwards -> normal start.
REQ-037 Step stalls (step low 3 cycles in round 1) -> rc held 0x8082; start pulsed while busy -> ignored.
REQ-038 rst asserted during RUN round 7 -> all outputs zero next cycle, no done; new start yields round-0 constant 0x1.
